// File: rtl/ins_rr_merge.sv
// ins_rr_merge: merges NUM_CH valid/ready input channels into one registered
// "ins" output stream. Each output word carries the index of the channel it
// came from. Arbitration is round-robin (RR_MODE=1) or fixed priority with
// the lowest index winning (RR_MODE=0). The output stage is a single register
// slice that sustains one word per cycle and holds its word under backpressure.
module ins_rr_merge #(
    parameter int WIDTH   = 3,
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = 1,
    localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    ins_valid,
    input  logic                    ins_ready,
    output logic [WIDTH-1:0]        ins,
    output logic [CHW-1:0]          ins_ch
);

    // Output register contents and round-robin pointer.
    logic               r_ins_valid;
    logic [WIDTH-1:0]   r_ins;
    logic [CHW-1:0]     r_ins_ch;
    logic [CHW-1:0]     r_ptr;

    // Arbitration and handshake terms.
    logic               w_load_en;
    logic               w_any_grant;
    logic               w_xfer;
    logic [NUM_CH-1:0]  w_mask;
    logic [NUM_CH-1:0]  w_masked;
    logic [NUM_CH-1:0]  w_req;
    logic [NUM_CH-1:0]  w_grant;
    logic [CHW-1:0]     w_grant_idx;
    logic [WIDTH-1:0]   w_grant_data;
    logic [CHW-1:0]     w_ptr_next;

    // The output register may take a new word when it is empty or is being
    // popped in this same cycle.
    assign w_load_en = !r_ins_valid || ins_ready;

    // Round-robin arbiter: requests at or above the pointer take precedence;
    // if none exist, wrap around to the lowest requesting channel. With the
    // mask forced to zero this degenerates into plain lowest-index priority.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_mask       = '0;
        w_grant      = '0;
        w_grant_idx  = '0;
        w_grant_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_mask[c] = (RR_MODE != 0) && (c >= int'(r_ptr));
        end
        w_masked    = in_valid & w_mask;
        w_req       = (|w_masked) ? w_masked : in_valid;
        w_any_grant = |w_req;
        // Scan downward so the lowest requesting index is the last one kept.
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_req[c]) begin
                w_grant     = '0;
                w_grant[c]  = 1'b1;
                w_grant_idx = CHW'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_grant[c]) begin
                w_grant_data = in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves to the channel after the one just served, wrapping at the top.
    always_comb begin
        w_ptr_next = '0;
        if (w_grant_idx != CHW'(NUM_CH - 1)) begin
            w_ptr_next = w_grant_idx + 1'b1;
        end
    end

    // Accept only the granted channel, only when the output register can load,
    // and never while reset is asserted.
    assign in_ready = (w_load_en && !reset) ? w_grant : '0;
    assign w_xfer   = w_load_en && w_any_grant && !reset;

    // Output register and arbitration pointer; reset discards any held word.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from the
        // pre-edge values, independent of statement order.
        if (reset) begin
            r_ins_valid <= 1'b0;
            r_ins       <= '0;
            r_ins_ch    <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_load_en) begin
                r_ins_valid <= w_xfer;
            end
            if (w_xfer) begin
                r_ins    <= w_grant_data;
                r_ins_ch <= w_grant_idx;
                if (RR_MODE != 0) begin
                    r_ptr <= w_ptr_next;
                end
            end
        end
    end

    assign ins_valid = r_ins_valid;
    assign ins       = r_ins;
    assign ins_ch    = r_ins_ch;

endmodule

// File: tb/tb_ins_rr_merge.sv
// Bench for ins_rr_merge: one round-robin instance and one fixed-priority
// instance, directed stimulus with hand-computed expected words pushed into
// per-instance queues, and monitors that pop and compare on each output pop.
module tb_ins_rr_merge;

    typedef struct {
        logic [1:0] ch;
        logic [2:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic [3:0]  rr_valid, rr_in_ready;
    logic [11:0] rr_data;
    logic        rr_ins_valid, rr_rdy;
    logic [2:0]  rr_ins;
    logic [1:0]  rr_ins_ch;

    logic [3:0]  fp_valid, fp_in_ready;
    logic [11:0] fp_data;
    logic        fp_ins_valid, fp_rdy;
    logic [2:0]  fp_ins;
    logic [1:0]  fp_ins_ch;

    exp_t rr_q[$];
    exp_t fp_q[$];

    int checks   = 0;
    int failures = 0;

    // Upstream-rule tracking: channels left pending at the previous sample.
    logic [3:0]  rr_pend = '0, fp_pend = '0;
    logic [11:0] rr_pdata = '0, fp_pdata = '0;
    logic        prev_rst = 1'b1;

    ins_rr_merge #(.WIDTH(3), .NUM_CH(4), .RR_MODE(1)) dut_rr (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rr_valid),
        .in_ready  (rr_in_ready),
        .in_data   (rr_data),
        .ins_valid (rr_ins_valid),
        .ins_ready (rr_rdy),
        .ins       (rr_ins),
        .ins_ch    (rr_ins_ch)
    );

    ins_rr_merge #(.WIDTH(3), .NUM_CH(4), .RR_MODE(0)) dut_fp (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (fp_valid),
        .in_ready  (fp_in_ready),
        .in_data   (fp_data),
        .ins_valid (fp_ins_valid),
        .ins_ready (fp_rdy),
        .ins       (fp_ins),
        .ins_ch    (fp_ins_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] pack4(input int d0, input int d1, input int d2, input int d3);
        return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    task automatic push_rr(input int ch, input int d);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = 3'(d);
        rr_q.push_back(e);
    endtask

    task automatic push_fp(input int ch, input int d);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = 3'(d);
        fp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rule_check(input string tag, input logic [3:0] pend, input logic [11:0] pdata,
                              input logic [3:0] v, input logic [11:0] d);
        for (int i = 0; i < 4; i++) begin
            if (pend[i]) begin
                check({tag, "_upstream_rule"}, {v[i], d[i*3 +: 3]}, {1'b1, pdata[i*3 +: 3]});
            end
        end
    endtask

    // Scoreboard monitor, round-robin instance: pop on each output transfer.
    always @(negedge clk) begin
        check("rr_in_ready_onehot0", 32'($onehot0(rr_in_ready)), 32'd1);
        if (!reset && rr_ins_valid === 1'b1 && rr_rdy === 1'b1) begin
            if (rr_q.size() == 0) begin
                check("rr_unexpected_word", 32'(rr_ins_valid), 32'd0);
            end else begin
                exp_t e;
                e = rr_q.pop_front();
                check("rr_ins_ch", 32'(rr_ins_ch), 32'(e.ch));
                check("rr_ins", 32'(rr_ins), 32'(e.data));
            end
        end
    end

    // Scoreboard monitor, fixed-priority instance.
    always @(negedge clk) begin
        check("fp_in_ready_onehot0", 32'($onehot0(fp_in_ready)), 32'd1);
        if (!reset && fp_ins_valid === 1'b1 && fp_rdy === 1'b1) begin
            if (fp_q.size() == 0) begin
                check("fp_unexpected_word", 32'(fp_ins_valid), 32'd0);
            end else begin
                exp_t e;
                e = fp_q.pop_front();
                check("fp_ins_ch", 32'(fp_ins_ch), 32'(e.ch));
                check("fp_ins", 32'(fp_ins), 32'(e.data));
            end
        end
    end

    // Upstream rule: a pending channel keeps valid and data until accepted.
    always @(negedge clk) begin
        if (!reset && !prev_rst) begin
            rule_check("rr", rr_pend, rr_pdata, rr_valid, rr_data);
            rule_check("fp", fp_pend, fp_pdata, fp_valid, fp_data);
        end
        rr_pend  <= rr_valid & ~rr_in_ready;
        rr_pdata <= rr_data;
        fp_pend  <= fp_valid & ~fp_in_ready;
        fp_pdata <= fp_data;
        prev_rst <= reset;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Test 1: reset held two cycles with every channel requesting.
        reset    = 1'b1;
        rr_valid = 4'b1111;
        rr_data  = pack4(4, 5, 6, 7);
        rr_rdy   = 1'b1;
        fp_valid = 4'b0000;
        fp_data  = '0;
        fp_rdy   = 1'b1;
        @(negedge clk);
        check("t1_rr_in_ready_rst", 32'(rr_in_ready), 32'h0);
        check("t1_fp_in_ready_rst", 32'(fp_in_ready), 32'h0);
        check("t1_rr_ins_valid_rst", 32'(rr_ins_valid), 32'h0);
        check("t1_fp_ins_valid_rst", 32'(fp_ins_valid), 32'h0);
        tick();
        check("t1_rr_ins_valid_rst2", 32'(rr_ins_valid), 32'h0);
        check("t1_rr_ins_rst", 32'(rr_ins), 32'h0);
        check("t1_rr_ins_ch_rst", 32'(rr_ins_ch), 32'h0);
        reset = 1'b0;

        // Test 2: round-robin fairness, then drain by dropping each served channel.
        push_rr(0, 4); push_rr(1, 5); push_rr(2, 6); push_rr(3, 7);
        push_rr(0, 4); push_rr(1, 5); push_rr(2, 6); push_rr(3, 7);
        @(negedge clk);
        check("t2_first_grant_ch0", 32'(rr_in_ready), 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("t2_ins_valid_streaming", 32'(rr_ins_valid), 32'h1);
        end
        tick(); rr_valid = 4'b1110;
        @(negedge clk); check("t2_ins_valid_drain0", 32'(rr_ins_valid), 32'h1);
        tick(); rr_valid = 4'b1100;
        @(negedge clk); check("t2_ins_valid_drain1", 32'(rr_ins_valid), 32'h1);
        tick(); rr_valid = 4'b1000;
        @(negedge clk); check("t2_ins_valid_drain2", 32'(rr_ins_valid), 32'h1);
        tick(); rr_valid = 4'b0000;
        @(negedge clk); check("t2_ins_valid_drain3", 32'(rr_ins_valid), 32'h1);
        tick();
        @(negedge clk); check("t2_ins_valid_empty", 32'(rr_ins_valid), 32'h0);

        // Test 3: backpressure with ch2 word 5 held; ch0 and ch3 wait behind it.
        tick();
        rr_data  = pack4(1, 0, 5, 3);
        rr_valid = 4'b0100;
        rr_rdy   = 1'b0;
        push_rr(2, 5); push_rr(3, 3); push_rr(0, 1);
        tick();
        rr_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_ins", 32'(rr_ins), 32'h5);
            check("t3_hold_ins_ch", 32'(rr_ins_ch), 32'h2);
            check("t3_hold_ins_valid", 32'(rr_ins_valid), 32'h1);
            check("t3_hold_in_ready", 32'(rr_in_ready), 32'h0);
            tick();
        end
        rr_rdy = 1'b1;
        @(negedge clk); check("t3_release_grant_ch3", 32'(rr_in_ready), 32'h8);
        tick(); rr_valid = 4'b0001;
        @(negedge clk); check("t3_then_grant_ch0", 32'(rr_in_ready), 32'h1);
        tick(); rr_valid = 4'b0000;
        @(negedge clk);
        tick();

        // Test 4: sparse requests on ch1 and ch3; pointer wraps past ch0/ch2.
        rr_data  = pack4(0, 2, 0, 6);
        rr_valid = 4'b1010;
        push_rr(1, 2); push_rr(3, 6); push_rr(1, 2); push_rr(3, 6); push_rr(1, 2);
        @(negedge clk); check("t4_grant_ch1_a", 32'(rr_in_ready), 32'h2);
        tick();
        @(negedge clk); check("t4_grant_ch3_a", 32'(rr_in_ready), 32'h8);
        tick();
        @(negedge clk); check("t4_wrap_grant_ch1", 32'(rr_in_ready), 32'h2);
        tick();
        @(negedge clk); check("t4_grant_ch3_b", 32'(rr_in_ready), 32'h8);
        tick(); rr_valid = 4'b0010;
        @(negedge clk); check("t4_grant_ch1_c", 32'(rr_in_ready), 32'h2);
        tick(); rr_valid = 4'b0000;
        @(negedge clk);
        tick();

        // Test 6: reset while a word is stalled; the word is lost, pointer returns to 0.
        rr_data  = pack4(1, 0, 7, 3);
        rr_valid = 4'b0100;
        rr_rdy   = 1'b0;
        tick();
        rr_valid = 4'b1001;
        @(negedge clk);
        check("t6_stalled_valid", 32'(rr_ins_valid), 32'h1);
        check("t6_stalled_ch", 32'(rr_ins_ch), 32'h2);
        check("t6_stalled_ins", 32'(rr_ins), 32'h7);
        tick();
        reset = 1'b1;
        @(negedge clk); check("t6_in_ready_in_reset", 32'(rr_in_ready), 32'h0);
        tick();
        check("t6_valid_cleared", 32'(rr_ins_valid), 32'h0);
        reset  = 1'b0;
        rr_rdy = 1'b1;
        push_rr(0, 1); push_rr(3, 3);
        @(negedge clk); check("t6_grant_ch0_after_reset", 32'(rr_in_ready), 32'h1);
        tick(); rr_valid = 4'b1000;
        @(negedge clk); check("t6_then_grant_ch3", 32'(rr_in_ready), 32'h8);
        tick(); rr_valid = 4'b0000;
        @(negedge clk);
        tick();

        // Test 5: fixed priority, ch0 and ch2 requesting; ch2 only after ch0 drops.
        fp_data  = pack4(2, 0, 5, 0);
        fp_valid = 4'b0101;
        push_fp(0, 2); push_fp(0, 2); push_fp(0, 2); push_fp(2, 5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_fp_grant_ch0", 32'(fp_in_ready), 32'h1);
            tick();
        end
        fp_valid = 4'b0100;
        @(negedge clk); check("t5_fp_grant_ch2", 32'(fp_in_ready), 32'h4);
        tick(); fp_valid = 4'b0000;
        @(negedge clk);
        tick();
        tick();

        check("rr_queue_drained", 32'(rr_q.size()), 32'd0);
        check("fp_queue_drained", 32'(fp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
